// File: rtl/io_port_responder_pkg.sv
// Shared definitions for the I/O port responder: the RX holding-state encoding
// and the default FIFO depth and word width.
package io_port_responder_pkg;

    localparam int DEFAULT_TX_DEPTH = 4;
    localparam int DEFAULT_WIDTH    = 16;

    typedef enum logic [1:0] {
        RX_EMPTY   = 2'd0,
        RX_FULL    = 2'd1,
        RX_RELEASE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/io_tx_fifo.sv
// CPU-to-device transmit FIFO. A write to a full FIFO is accepted when a pop
// happens on the same edge; otherwise it is dropped and the sticky overflow flag is set.
module io_tx_fifo
    import io_port_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_TX_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic w_pop;
    logic w_full;
    logic w_push;

    // pop is the device's ready; it only counts when there is a word to take
    assign w_pop  = pop && (r_count != '0);
    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (push && !w_push) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout     = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped I/O port: buffers CPU stores towards a device through a FIFO and
// holds one received device word for the CPU, raising an interrupt while it waits.
module io_port_responder
    import io_port_responder_pkg::*;
#(
    parameter int TX_DEPTH = DEFAULT_TX_DEPTH,
    parameter int WIDTH    = DEFAULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            cpu_data_out,
    input  logic                        cpu_wr,
    input  logic                        cpu_rd_ack,
    output logic [WIDTH-1:0]            cpu_data_in,
    output logic                        interrupt,
    output logic [WIDTH-1:0]            dev_tx_data,
    output logic                        dev_tx_valid,
    input  logic                        dev_tx_ready,
    input  logic [WIDTH-1:0]            dev_rx_data,
    input  logic                        dev_rx_valid,
    output logic                        dev_rx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic                        tx_overflow
);

    logic [$clog2(TX_DEPTH):0] w_tx_count;

    io_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (WIDTH)
    ) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cpu_wr),
        .din      (cpu_data_out),
        .pop      (dev_tx_ready),
        .dout     (dev_tx_data),
        .count    (w_tx_count),
        .overflow (tx_overflow)
    );

    assign tx_count     = w_tx_count;
    assign dev_tx_valid = (w_tx_count != '0);

    rx_state_t        r_state;
    logic [WIDTH-1:0] r_rx_hold;
    logic             r_interrupt;
    logic             r_rx_ready;

    // interrupt and ready are registered alongside the state so they track
    // RX_FULL and RX_EMPTY exactly, with no combinational decode on the outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= RX_EMPTY;
            r_rx_hold   <= '0;
            r_interrupt <= 1'b0;
            r_rx_ready  <= 1'b1;
        end else begin
            case (r_state)
                RX_EMPTY: begin
                    if (dev_rx_valid) begin
                        r_rx_hold   <= dev_rx_data;
                        r_state     <= RX_FULL;
                        r_interrupt <= 1'b1;
                        r_rx_ready  <= 1'b0;
                    end
                end
                RX_FULL: begin
                    if (cpu_rd_ack) begin
                        r_state     <= RX_RELEASE;
                        r_interrupt <= 1'b0;
                    end
                end
                RX_RELEASE: begin
                    // one forced idle cycle guarantees an interrupt-low gap
                    r_state    <= RX_EMPTY;
                    r_rx_ready <= 1'b1;
                end
                default: begin
                    r_state     <= RX_EMPTY;
                    r_interrupt <= 1'b0;
                    r_rx_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_data_in  = r_rx_hold;
    assign interrupt    = r_interrupt;
    assign dev_rx_ready = r_rx_ready;

endmodule

// File: doc/io_port_responder.md
IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 Parameter TX_DEPTH, default 4: TX FIFO depth in words; power of two, minimum 2.
REQ-002 Parameter WIDTH, default 16: data word width; matches the CPU datapath.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
REQ-005 cpu_data_out  input  WIDTH  store word presented by the CPU execution stage.
REQ-006 cpu_wr  input  1  CPU store strobe; pushes cpu_data_out into the TX FIFO.
REQ-007 cpu_rd_ack  input  1  CPU has consumed cpu_data_in; releases the RX holding register.
REQ-008 cpu_data_in  output  WIDTH  RX word driven to the CPU data_in.
REQ-009 interrupt  output  1  level request to the CPU interrupt input.
REQ-010 dev_tx_data  output  WIDTH  head word of the TX FIFO.
REQ-011 dev_tx_valid  output  1  TX FIFO is non-empty.
REQ-012 dev_tx_ready  input  1  device accepts dev_tx_data this cycle.
REQ-013 dev_rx_data  input  WIDTH  word offered by the device.
REQ-014 dev_rx_valid  input  1  dev_rx_data is valid.
REQ-015 dev_rx_ready  output  1  responder accepts dev_rx_data this cycle.
REQ-016 tx_count  output  log2(TX_DEPTH)+1  current TX FIFO occupancy.
REQ-017 tx_overflow  output  1  sticky flag: a CPU write was dropped.

Function
REQ-018 A TX pop occurs on an edge where dev_tx_valid=1 and dev_tx_ready=1.
REQ-019 A TX push occurs on an edge where cpu_wr=1 and either tx_count<TX_DEPTH or a pop happens on the same edge.
REQ-020 On a push with tx_count=TX_DEPTH and no pop, the word is dropped, tx_overflow is set, and tx_count is unchanged.
REQ-021 Read and write pointers wrap modulo TX_DEPTH; tx_count increments on push-only, decrements on pop-only, and holds on push+pop or on neither.
REQ-022 dev_tx_valid=(tx_count!=0); dev_tx_data=mem[rd_ptr]; both are combinational from registered state.
REQ-023 A pushed word is visible on dev_tx_data one cycle after the push when the FIFO was empty; words leave the FIFO in push order.
REQ-024 The RX FSM has three states: RX_EMPTY, RX_FULL, RX_RELEASE.
REQ-025 In RX_EMPTY: dev_rx_ready=1; dev_rx_valid=1 latches dev_rx_data into rx_hold and moves to RX_FULL.
REQ-026 In RX_FULL: dev_rx_ready=0, interrupt=1, cpu_data_in=rx_hold; cpu_rd_ack=1 moves to RX_RELEASE.
REQ-027 In RX_RELEASE: dev_rx_ready=0, interrupt=0; the FSM returns unconditionally to RX_EMPTY, which guarantees an interrupt-low gap of at least one cycle between successive words.
REQ-028 interrupt is registered and equals (state==RX_FULL).
REQ-029 cpu_rd_ack is ignored in RX_EMPTY and RX_RELEASE; dev_rx_valid is ignored outside RX_EMPTY.
REQ-030 cpu_data_in holds rx_hold in every state; it changes only on capture.
REQ-031 The TX and RX paths are independent; simultaneous events on both paths in one cycle are all honoured.

Reset
REQ-032 With reset=0 at a clock edge: pointers=0, tx_count=0, tx_overflow=0, rx_hold=0, FSM=RX_EMPTY.
REQ-033 After reset: dev_tx_valid=0, dev_rx_ready=1, interrupt=0, cpu_data_in=0.
REQ-034 Reset takes priority over every concurrent push, pop, capture or acknowledge; FIFO contents are discarded mid-operation.
REQ-035 FIFO storage is not required to clear on reset; it is unobservable while tx_count=0.

Structure
REQ-036 The shared package holds the RX state encoding (2-bit: RX_EMPTY=0, RX_FULL=1, RX_RELEASE=2) and the default TX_DEPTH and WIDTH constants.
REQ-037 The TX FIFO is a sub-module named io_tx_fifo (ports: clk, reset, push, din, pop, dout, count, overflow); the RX FSM stays in the top.

Verification
REQ-038 Push 0x1111, 0x2222, 0x3333 with dev_tx_ready=0, then hold ready=1 -> dev_tx_data shows 0x1111, 0x2222, 0x3333 on consecutive cycles, then dev_tx_valid=0.
REQ-039 Push 5 words with ready=0 -> tx_count=4, tx_overflow=1, and the 5th word is never emitted.
REQ-040 FIFO full, cpu_wr=1 and dev_tx_ready=1 on the same edge -> the push is accepted, tx_count stays 4, tx_overflow stays 0.
REQ-041 dev_rx_valid with 0xBEEF -> next cycle interrupt=1, cpu_data_in=0xBEEF, dev_rx_ready=0; a second word 0xCAFE is held off until after cpu_rd_ack plus one RX_RELEASE cycle, then captured.
REQ-042 reset=0 asserted while in RX_FULL with tx_count=3 -> next cycle interrupt=0, tx_count=0, dev_rx_ready=1, cpu_data_in=0.
